// File: rtl/nios2_fmeas_pkg.sv
// Shared encodings for the nios2_fmeasure_capture register map.
// Address sel values and STATUS/CTRL bit positions.
package nios2_fmeas_pkg;

    typedef enum logic [1:0] {
        SEL_DATA   = 2'd0,
        SEL_TSTAMP = 2'd1,
        SEL_STATUS = 2'd2,
        SEL_CTRL   = 2'd3
    } sel_e;

    localparam int STAT_FRESH_BIT = 0;
    localparam int STAT_OVR_BIT   = 1;
    localparam int CTRL_IRQEN_BIT = 0;

endpackage

// File: rtl/nios2_fmeas_chan.sv
// One measurement channel: holding register, fresh/overrun flags, irq enable.
// Timestamp holding register exists only with NIOS2_FMEAS_TSTAMP_EN defined.
module nios2_fmeas_chan #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cap,
    input  logic [W-1:0] cap_data,
`ifdef NIOS2_FMEAS_TSTAMP_EN
    input  logic [31:0]  cap_ts,
    output logic [31:0]  tstamp,
`endif
    input  logic         rd_clr,
    input  logic         ovr_clr,
    input  logic         ctrl_wr,
    input  logic         ctrl_en,
    output logic [W-1:0] data,
    output logic         fresh,
    output logic         overrun,
    output logic         irq_en
);

    // Sample capture; a capture always overwrites the held value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (cap) begin
            data <= cap_data;
        end
    end

`ifdef NIOS2_FMEAS_TSTAMP_EN
    // Timestamp latched alongside every capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tstamp <= '0;
        end else if (cap) begin
            tstamp <= cap_ts;
        end
    end
`endif

    // Flags: capture beats the read-clear; an overrun set beats the W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fresh   <= 1'b0;
            overrun <= 1'b0;
            irq_en  <= 1'b0;
        end else begin
            if (cap) begin
                fresh <= 1'b1;
            end else if (rd_clr) begin
                fresh <= 1'b0;
            end
            if (cap && fresh && !rd_clr) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_en <= ctrl_en;
            end
        end
    end

endmodule

// File: rtl/nios2_fmeasure_capture.sv
// Multi-channel strobe-qualified measurement capture, Avalon-MM slave.
// Define NIOS2_FMEAS_TSTAMP_EN to add the cycle counter and TSTAMP registers.
module nios2_fmeasure_capture #(
    parameter int NCH     = 4,
    parameter int W       = 32,
    parameter int CH_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chipselect,
    input  logic [CH_BITS+1:0]   address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic [NCH*W-1:0]     in_data,
    input  logic [NCH-1:0]       in_valid
);

    import nios2_fmeas_pkg::*;

    logic [CH_BITS-1:0] ch;
    sel_e               sel;
    logic               ch_ok;
    logic               rd;
    logic               wr;

    logic [W-1:0]       data_q [NCH];
    logic [NCH-1:0]     fresh;
    logic [NCH-1:0]     overrun;
    logic [NCH-1:0]     irq_en;
    logic [NCH-1:0]     rd_clr;
    logic [NCH-1:0]     ovr_clr;
    logic [NCH-1:0]     ctrl_wr;
    logic [31:0]        rmux;
    logic               unused_wd;

    assign ch    = address[CH_BITS+1:2];
    assign sel   = sel_e'(address[1:0]);
    assign ch_ok = int'(ch) < NCH;
    assign rd    = chipselect && read && ch_ok;
    assign wr    = chipselect && write && ch_ok;

    assign unused_wd = ^writedata[31:2];

`ifdef NIOS2_FMEAS_TSTAMP_EN
    logic [31:0] cnt;
    logic [31:0] ts_q [NCH];

    // Free-running cycle counter; wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        nios2_fmeas_chan #(
            .W(W)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .cap      (in_valid[g]),
            .cap_data (in_data[g*W +: W]),
`ifdef NIOS2_FMEAS_TSTAMP_EN
            .cap_ts   (cnt),
            .tstamp   (ts_q[g]),
`endif
            .rd_clr   (rd_clr[g]),
            .ovr_clr  (ovr_clr[g]),
            .ctrl_wr  (ctrl_wr[g]),
            .ctrl_en  (writedata[CTRL_IRQEN_BIT]),
            .data     (data_q[g]),
            .fresh    (fresh[g]),
            .overrun  (overrun[g]),
            .irq_en   (irq_en[g])
        );
    end

    // Per-channel strobe decode and read-data select.
    always_comb begin
        rd_clr  = '0;
        ovr_clr = '0;
        ctrl_wr = '0;
        rmux    = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch == CH_BITS'(c)) begin
                rd_clr[c]  = rd && (sel == SEL_DATA);
                ovr_clr[c] = wr && (sel == SEL_STATUS)
                             && writedata[STAT_OVR_BIT];
                ctrl_wr[c] = wr && (sel == SEL_CTRL);
                if (ch_ok) begin
                    unique case (sel)
                        SEL_DATA: rmux = 32'(data_q[c]);
`ifdef NIOS2_FMEAS_TSTAMP_EN
                        SEL_TSTAMP: rmux = ts_q[c];
`else
                        SEL_TSTAMP: rmux = '0;
`endif
                        SEL_STATUS: begin
                            rmux[STAT_FRESH_BIT] = fresh[c];
                            rmux[STAT_OVR_BIT]   = overrun[c];
                        end
                        SEL_CTRL: rmux[CTRL_IRQEN_BIT] = irq_en[c];
                    endcase
                end
            end
        end
    end

    // Registered read data and level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= (chipselect && read) ? rmux : 32'd0;
            irq      <= |(fresh & irq_en);
        end
    end

endmodule

// File: tb/tb_nios2_fmeasure_capture.sv
// Scoreboard bench for nios2_fmeasure_capture: directed cases plus random traffic.
// Reference model holds per-channel sample/flag state and a cycle count.
module tb_nios2_fmeasure_capture;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int CHB = 2;
    localparam int AW  = CHB + 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              chipselect = 1'b0;
    logic [AW-1:0]     address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NCH*W-1:0]  in_data = '0;
    logic [NCH-1:0]    in_valid = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] expq [$];

    logic [W-1:0]   m_data [NCH];
    logic [31:0]    m_ts   [NCH];
    logic [NCH-1:0] m_fresh;
    logic [NCH-1:0] m_ovr;
    logic [NCH-1:0] m_en;
    logic           m_irq;
    logic [31:0]    tb_cyc;

    nios2_fmeasure_capture #(
        .NCH(NCH), .W(W), .CH_BITS(CHB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_data    (in_data),
        .in_valid   (in_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 32'd0;
        else          tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a read accepted at an edge has its data one delta later.
    always @(posedge clk) begin
        logic r;
        r = chipselect && read && reset_n;
        #1;
        if (r) begin
            if (expq.size() == 0) begin
                check("readdata_unexpected", readdata, 32'hDEAD_BEEF);
            end else begin
                check("readdata", readdata, expq.pop_front());
            end
        end
    end

    function automatic logic [AW-1:0] A(input int c, input int s);
        return AW'(c * 4 + s);
    endfunction

    function automatic logic [NCH*W-1:0] D1(input int c,
                                            input logic [W-1:0] v);
        logic [NCH*W-1:0] d;
        d = '0;
        d[c*W +: W] = v;
        return d;
    endfunction

    function automatic logic [31:0] model_read(input int c, input int s);
        logic [31:0] r;
        r = 32'd0;
        if (c < NCH) begin
            case (s)
                0: r = 32'(m_data[c]);
`ifdef NIOS2_FMEAS_TSTAMP_EN
                1: r = m_ts[c];
`endif
                2: r = {30'd0, m_ovr[c], m_fresh[c]};
                3: r = {31'd0, m_en[c]};
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_data[c] = '0;
            m_ts[c]   = '0;
        end
        m_fresh = '0;
        m_ovr   = '0;
        m_en    = '0;
        m_irq   = 1'b0;
    endtask

    // One bus/strobe cycle; expected read pushed, model advanced one edge.
    task automatic cyc(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [NCH-1:0] v,
                       input logic [NCH*W-1:0] d);
        int ch;
        int sel;
        logic [NCH-1:0] nf;
        logic [NCH-1:0] no;
        @(negedge clk);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        chipselect = rd | wr;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        in_valid   = v;
        in_data    = d;
        ch  = int'(a) / 4;
        sel = int'(a) % 4;
        if (rd) expq.push_back(model_read(ch, sel));
        m_irq = |(m_fresh & m_en);
        nf = m_fresh;
        no = m_ovr;
        for (int c = 0; c < NCH; c++) begin
            bit rclr;
            rclr = rd && ch == c && sel == 0;
            if (v[c]) begin
                if (m_fresh[c] && !rclr) no[c] = 1'b1;
                nf[c] = 1'b1;
                m_data[c] = d[c*W +: W];
                m_ts[c]   = tb_cyc;
            end else if (rclr) begin
                nf[c] = 1'b0;
            end
            if (!(v[c] && m_fresh[c] && !rclr) && wr && ch == c
                && sel == 2 && wd[1]) no[c] = 1'b0;
            if (wr && ch == c && sel == 3) m_en[c] = wd[0];
        end
        m_fresh = nf;
        m_ovr   = no;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, '0);
    endtask

    task automatic rd_reg(input int c, input int s);
        cyc(1, 0, A(c, s), '0, '0, '0);
    endtask

    task automatic wr_reg(input int c, input int s, input logic [31:0] v);
        cyc(0, 1, A(c, s), v, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        chipselect = 0; read = 0; write = 0;
        in_valid = '0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset state of every register.
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++) rd_reg(c, s);

        // Capture, fresh, read-clear.
        cyc(0, 0, '0, '0, 4'b0010, D1(1, 32'h0001_2345));
        rd_reg(1, 2);
        rd_reg(1, 0);
        rd_reg(1, 2);
        rd_reg(1, 1);

        // Overrun and W1C.
        cyc(0, 0, '0, '0, 4'b0100, D1(2, 32'hA));
        cyc(0, 0, '0, '0, 4'b0100, D1(2, 32'hB));
        rd_reg(2, 0);
        rd_reg(2, 2);
        wr_reg(2, 2, 32'h2);
        rd_reg(2, 2);

        // Capture racing a DATA read.
        cyc(0, 0, '0, '0, 4'b0001, D1(0, 32'h44));
        rd_reg(0, 0);
        cyc(1, 0, A(0, 0), '0, 4'b0001, D1(0, 32'h55));
        rd_reg(0, 2);
        rd_reg(0, 0);

        // Overrun set racing W1C.
        cyc(0, 0, '0, '0, 4'b0010, D1(1, 32'h1));
        cyc(0, 1, A(1, 2), 32'h2, 4'b0010, D1(1, 32'h2));
        rd_reg(1, 2);

        // IRQ enable, assert, clear by read, disabled channel.
        wr_reg(3, 3, 32'h1);
        rd_reg(3, 3);
        cyc(0, 0, '0, '0, 4'b1000, D1(3, 32'h77));
        idle(2);
        rd_reg(3, 0);
        idle(2);
        wr_reg(3, 3, 32'h0);
        cyc(0, 0, '0, '0, 4'b1000, D1(3, 32'h78));
        idle(3);
        rd_reg(3, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rd;
            bit wr;
            logic [NCH-1:0] v;
            logic [NCH*W-1:0] d;
            rd = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 4) == 0);
            for (int c = 0; c < NCH; c++) begin
                v[c] = ($urandom_range(0, 5) == 0);
                d[c*W +: W] = W'($urandom);
            end
            cyc(rd, wr, AW'($urandom_range(0, (1 << AW) - 1)),
                $urandom, v, d);
            if (i == 1500) begin
                idle(1);
                do_reset();
                for (int c = 0; c < NCH; c++) rd_reg(c, 2);
            end
        end

        idle(3);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
